// File: rtl/poly_tone_synth.sv
// poly_tone_synth: N_CH-channel gated square-wave generator, each channel fixed tone or triangular sweep.
// Define POLY_TONE_SYNTH_PRESCALE_EN to run tones and sweeps on a half-rate tick.
module poly_tone_synth #(
   parameter int N_CH = 4,
   parameter int PW = 16,
   parameter int SWEEP_DIV = 65536,
   parameter int SPANW = 7,
   parameter int SWEEP_SPAN = 127,
   parameter int CHW = (N_CH > 1) ? $clog2(N_CH) : 1,
   parameter int MW = $clog2(N_CH + 1)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            wr_en,
   input  logic [CHW-1:0]  wr_ch,
   input  logic [PW-1:0]   wr_period,
   input  logic            wr_sweep,
   output logic            wr_ack,
   input  logic [N_CH-1:0] gate,
   output logic [N_CH-1:0] ch_out,
   output logic            spk,
   output logic [MW-1:0]   mix
);
   localparam int SDW = (SWEEP_DIV > 1) ? $clog2(SWEEP_DIV) : 1;
   logic tick, wrap, wr_ok;
   logic [SDW-1:0] scnt;
   logic [N_CH-1:0] phase, lit;
   logic [MW-1:0] pc;
`ifdef POLY_TONE_SYNTH_PRESCALE_EN
   logic tick_q;
   always_ff @(posedge clk) tick_q <= reset ? 1'b0 : ~tick_q;
   assign tick = tick_q;
`else
   assign tick = 1'b1;
`endif
   assign wr_ok = wr_en && ({1'b0, wr_ch} < (CHW + 1)'(N_CH));
   assign wrap = tick && (scnt == SDW'(SWEEP_DIV - 1));
   always_ff @(posedge clk)
      if (reset) scnt <= '0;
      else if (tick) scnt <= wrap ? '0 : scnt + 1'b1;
   for (genvar c = 0; c < N_CH; c++) begin : g_ch
      logic [PW-1:0] period;
      logic [PW:0] cnt, eff;
      logic [SPANW-1:0] offset;
      logic mode, dir, ph;
      // eff is one bit wider than period so period + offset never wraps
      assign eff = {1'b0, period} + (PW + 1)'(offset);
      assign phase[c] = ph;
      always_ff @(posedge clk)
         if (reset) begin
            period <= '0;
            mode <= 1'b0;
            dir <= 1'b0;
            cnt <= '0;
            ph <= 1'b0;
            offset <= '0;
         end else if (wr_ok && wr_ch == CHW'(c)) begin
            period <= wr_period;
            mode <= wr_sweep;
            dir <= 1'b0;
            cnt <= '0;
            ph <= 1'b0;
            offset <= '0;
         end else if (tick) begin
            if (period == '0) begin
               cnt <= '0;
               ph <= 1'b0;
            end else if (cnt >= eff - 1'b1) begin
               cnt <= '0;
               ph <= ~ph;
            end else cnt <= cnt + 1'b1;
            if (mode && wrap) begin
               if (!dir && offset == SPANW'(SWEEP_SPAN)) begin
                  dir <= 1'b1;
                  offset <= offset - 1'b1;
               end else if (dir && offset == '0) begin
                  dir <= 1'b0;
                  offset <= offset + 1'b1;
               end else offset <= dir ? offset - 1'b1 : offset + 1'b1;
            end
         end
   end
   assign lit = phase & gate;
   always_comb begin
      pc = '0;
      for (int i = 0; i < N_CH; i++) pc = pc + MW'(lit[i]);
   end
   always_ff @(posedge clk)
      if (reset) begin
         ch_out <= '0;
         spk <= 1'b0;
         mix <= '0;
         wr_ack <= 1'b0;
      end else begin
         ch_out <= lit;
         spk <= |lit;
         mix <= pc;
         wr_ack <= wr_ok;
      end
endmodule

// File: tb/tb_poly_tone_synth.sv
// tb_poly_tone_synth: directed and random stimulus against a tick-level behavioural model.
module tb_poly_tone_synth;
   localparam int N = 3, DIV = 4, SPAN = 3;
   logic clk = 1'b0;
   logic reset, wr_en, wr_sweep, wr_ack, spk;
   logic [1:0] wr_ch, mix, e_mix;
   logic [7:0] wr_period;
   logic [2:0] gate, ch_out, e_ch;
   logic e_spk, e_ack;
   int per[N], sw[N], cnt[N], ph[N], k[N];
   int tc, tk, nvec, nerr;

   always #5 clk = ~clk;

   poly_tone_synth #(.N_CH(3), .PW(8), .SWEEP_DIV(DIV), .SPANW(2), .SWEEP_SPAN(SPAN)) dut (
      .clk(clk), .reset(reset), .wr_en(wr_en), .wr_ch(wr_ch), .wr_period(wr_period),
      .wr_sweep(wr_sweep), .wr_ack(wr_ack), .gate(gate), .ch_out(ch_out), .spk(spk), .mix(mix)
   );

   // sweep offset after s steps follows a triangle 0..SPAN..0 of period 2*SPAN
   function automatic int tri_off(int s);
      int p;
      p = s % (2 * SPAN);
      return (p <= SPAN) ? p : 2 * SPAN - p;
   endfunction

   task automatic model();
      bit tick, wrap;
      int lit;
      lit = 0;
      for (int i = 0; i < N; i++) if (ph[i] != 0 && gate[i]) lit |= (1 << i);
      e_ch = reset ? 3'd0 : 3'(lit);
      e_spk = !reset && lit != 0;
      e_mix = reset ? 2'd0 : 2'($countones(3'(lit)));
      e_ack = !reset && wr_en && wr_ch < N;
      if (reset) begin
         tc = 0;
         tk = 0;
         for (int i = 0; i < N; i++) begin
            per[i] = 0; sw[i] = 0; cnt[i] = 0; ph[i] = 0; k[i] = 0;
         end
      end else begin
`ifdef POLY_TONE_SYNTH_PRESCALE_EN
         tick = (tk == 1);
         tk = 1 - tk;
`else
         tick = 1'b1;
`endif
         wrap = tick && (tc % DIV == DIV - 1);
         if (tick) tc++;
         for (int i = 0; i < N; i++) begin
            if (wr_en && wr_ch == i) begin
               per[i] = wr_period; sw[i] = wr_sweep; cnt[i] = 0; ph[i] = 0; k[i] = 0;
            end else if (tick) begin
               if (per[i] == 0) begin
                  cnt[i] = 0; ph[i] = 0;
               end else if (cnt[i] >= per[i] + tri_off(k[i]) - 1) begin
                  cnt[i] = 0; ph[i] = 1 - ph[i];
               end else cnt[i]++;
               if (wrap && sw[i] != 0) k[i] = (k[i] + 1) % (2 * SPAN);
            end
         end
      end
   endtask

   task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      model();
      #1;
      chk("ch_out", 8'(ch_out), 8'(e_ch));
      chk("spk", 8'(spk), 8'(e_spk));
      chk("mix", 8'(mix), 8'(e_mix));
      chk("wr_ack", 8'(wr_ack), 8'(e_ack));
   endtask

   task automatic run(int n);
      repeat (n) cyc();
   endtask

   task automatic wr(int ch, int p, bit s);
      wr_en = 1'b1;
      wr_ch = 2'(ch);
      wr_period = 8'(p);
      wr_sweep = s;
      cyc();
      wr_en = 1'b0;
   endtask

   initial begin
      nvec = 0;
      nerr = 0;
      reset = 1'b1;
      wr_en = 1'b0;
      wr_ch = '0;
      wr_period = '0;
      wr_sweep = 1'b0;
      gate = '0;
      run(2);
      reset = 1'b0;
      gate = 3'b001;
      wr(0, 4, 1'b0);
      run(24);
      gate = 3'b111;
      wr(1, 0, 1'b0);
      run(20);
      gate = 3'b011;
      wr(0, 3, 1'b0);
      wr(1, 5, 1'b0);
      run(40);
      gate = 3'b001;
      wr(0, 10, 1'b1);
      run(250);
      wr(3, 7, 1'b1);
      run(6);
      for (int i = 0; i < 40 && ch_out[0] !== 1'b1; i++) cyc();
      gate = 3'b000;
      run(5);
      gate = 3'b001;
      run(20);
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      run(20);
      repeat (800) begin
         reset = ($urandom_range(0, 99) == 0);
         wr_en = ($urandom_range(0, 5) == 0);
         wr_ch = 2'($urandom_range(0, 3));
         wr_period = 8'($urandom_range(0, 12));
         wr_sweep = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 15) == 0) gate = 3'($urandom);
         cyc();
      end
      reset = 1'b0;
      wr_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
